// File: rtl/tetris_pkg.sv
// Shared definitions for the line-clear controller.
//  - grid geometry: 7 columns x 7 rows packed into 49 bits, row r at [7r+6:7r]
//  - controller state encoding
//  - default per-pass score values
package tetris_pkg;

  localparam int GRID_W    = 7;
  localparam int GRID_H    = 7;
  localparam int GRID_BITS = GRID_W * GRID_H;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } lc_state_e;

  localparam logic [15:0] SCORE_1_DEF = 16'd40;
  localparam logic [15:0] SCORE_2_DEF = 16'd100;
  localparam logic [15:0] SCORE_3_DEF = 16'd300;
  localparam logic [15:0] SCORE_4_DEF = 16'd1200;

endpackage

// File: rtl/row_full_detect.sv
// Combinational full-row finder.
//  grid_i     : 49-bit grid, row r at [7r+6:7r]
//  any_full_o : at least one row has all 7 cells set
//  hi_row_o   : index of the highest-numbered (lowest on screen) full row
module row_full_detect
  import tetris_pkg::*;
(
  input  logic [GRID_BITS-1:0] grid_i,
  output logic                 any_full_o,
  output logic [2:0]           hi_row_o
);

  logic [GRID_H-1:0] full;

  always_comb begin
    full     = '0;
    hi_row_o = 3'd0;
    for (int r = 0; r < GRID_H; r++) begin
      full[r] = &grid_i[GRID_W*r +: GRID_W];
    end
    // ascending scan, so the last match (highest index) wins
    for (int r = 0; r < GRID_H; r++) begin
      if (full[r]) hi_row_o = 3'(r);
    end
    any_full_o = |full;
  end

endmodule

// File: rtl/line_clear_ctrl.sv
// Line-clear controller: after a piece lands, repeatedly asks the external
// row shifter to remove the lowest full row until none remain, then reports
// the cleaned grid, the number of lines removed and a saturating score.
//  clk, reset          : clock, async active-high reset
//  start, grid_in      : begin a pass on grid_in (ignored while busy)
//  sh_grid/sh_row/sh_en: drive the shifter; sh_new_grid is its result
//  grid_out            : working grid, final when done pulses
//  busy, done          : pass in progress / one-cycle completion pulse
//  lines_cleared, score: rows removed in last pass, running total
//
//  state | meaning
//  IDLE  | waiting for start
//  SCAN  | look for a full row in the working grid
//  CLEAR | shifter removes sel_row; capture its result
//  DONE  | pulse done, add points for this pass
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter logic [15:0] SCORE_1 = SCORE_1_DEF,
  parameter logic [15:0] SCORE_2 = SCORE_2_DEF,
  parameter logic [15:0] SCORE_3 = SCORE_3_DEF,
  parameter logic [15:0] SCORE_4 = SCORE_4_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [GRID_BITS-1:0] grid_in,
  output logic [GRID_BITS-1:0] sh_grid,
  output logic [2:0]           sh_row,
  output logic                 sh_en,
  input  logic [GRID_BITS-1:0] sh_new_grid,
  output logic [GRID_BITS-1:0] grid_out,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           lines_cleared,
  output logic [15:0]          score
);

  lc_state_e            state_q, state_d;
  logic [GRID_BITS-1:0] work_q, work_d;
  logic [2:0]           sel_q, sel_d;
  logic [2:0]           lines_q, lines_d;
  logic [15:0]          score_q, score_d;

  logic                 any_full;
  logic [2:0]           hi_row;
  logic [15:0]          pts;
  logic [16:0]          score_sum;

  row_full_detect u_detect (
    .grid_i     (work_q),
    .any_full_o (any_full),
    .hi_row_o   (hi_row)
  );

  always_comb begin
    case (lines_q)
      3'd0:    pts = 16'd0;
      3'd1:    pts = SCORE_1;
      3'd2:    pts = SCORE_2;
      3'd3:    pts = SCORE_3;
      default: pts = SCORE_4;
    endcase
    score_sum = {1'b0, score_q} + {1'b0, pts};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      sel_q   <= '0;
      lines_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      sel_q   <= sel_d;
      lines_q <= lines_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    sel_d   = sel_q;
    lines_d = lines_q;
    score_d = score_q;
    sh_en   = 1'b0;
    sh_row  = 3'd0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d  = grid_in;
          lines_d = 3'd0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (any_full) begin
          sel_d   = hi_row;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_CLEAR: begin
        sh_en   = 1'b1;
        sh_row  = sel_q;
        work_d  = sh_new_grid;
        lines_d = lines_q + 3'd1;
        // always rescan: removing a row moves the remaining full rows down
        state_d = ST_SCAN;
      end
      ST_DONE: begin
        done    = 1'b1;
        score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sh_grid       = work_q;
  assign grid_out      = work_q;
  assign busy          = (state_q != ST_IDLE);
  assign lines_cleared = lines_q;
  assign score         = score_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
module tb_line_clear_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [48:0] grid_in = '0;

  logic [48:0] sh_grid, sh_new_grid, grid_out;
  logic [2:0]  sh_row, lines_cleared;
  logic        sh_en, busy, done;
  logic [15:0] score;

  logic [48:0] sh_grid2, sh_new_grid2, grid_out2;
  logic [2:0]  sh_row2, lines_cleared2;
  logic        sh_en2, busy2, done2;
  logic [15:0] score2;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_score1 = 0;
  int exp_score2 = 0;

  logic [48:0] m_grid;
  int          m_n;
  int          m_rows[7];

  always #5 clk = ~clk;

  // behavioural shifter: remove row, rows above drop by one, top zero-filled
  function automatic logic [48:0] shift_fn(logic [48:0] g, logic [2:0] row, logic en);
    logic [48:0] o;
    o = g;
    if (en) begin
      for (int r = 0; r < 7; r++) begin
        if (r <= int'(row)) o[7*r +: 7] = (r == 0) ? 7'd0 : g[7*(r-1) +: 7];
      end
    end
    return o;
  endfunction

  assign sh_new_grid  = shift_fn(sh_grid, sh_row, sh_en);
  assign sh_new_grid2 = shift_fn(sh_grid2, sh_row2, sh_en2);

  line_clear_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .grid_in(grid_in),
    .sh_grid(sh_grid), .sh_row(sh_row), .sh_en(sh_en), .sh_new_grid(sh_new_grid),
    .grid_out(grid_out), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .score(score)
  );

  line_clear_ctrl #(.SCORE_4(16'hFFF0)) dut2 (
    .clk(clk), .reset(reset), .start(start), .grid_in(grid_in),
    .sh_grid(sh_grid2), .sh_row(sh_row2), .sh_en(sh_en2), .sh_new_grid(sh_new_grid2),
    .grid_out(grid_out2), .busy(busy2), .done(done2),
    .lines_cleared(lines_cleared2), .score(score2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: full rows vanish, surviving rows keep order and settle at the bottom
  task automatic model(input logic [48:0] g);
    int fl[7];
    int k;
    int dst;
    k = 0;
    m_grid = '0;
    for (int r = 6; r >= 0; r--) if (g[7*r +: 7] == 7'h7F) begin fl[k] = r; k++; end
    m_n = k;
    for (int i = 0; i < 7; i++) m_rows[i] = (i < k) ? fl[i] + i : 0;
    dst = 6;
    for (int r = 6; r >= 0; r--) begin
      if (g[7*r +: 7] != 7'h7F) begin
        m_grid[7*dst +: 7] = g[7*r +: 7];
        dst--;
      end
    end
  endtask

  function automatic int pts(int n, int s4);
    case (n)
      0: return 0;
      1: return 40;
      2: return 100;
      3: return 300;
      default: return s4;
    endcase
  endfunction

  function automatic int sat(int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic run_pass(input string nm, input logic [48:0] g, input logic [48:0] eg,
                          input int en, input int er[7], input bit inject);
    int  c, k;
    bit  got_done, got_done2, rows_ok, stray_row, injected;
    @(negedge clk);
    grid_in = g;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0; k = 0; got_done = 0; got_done2 = 0; rows_ok = 1; stray_row = 0; injected = 0;
    while (!got_done && c < 40) begin
      @(negedge clk);
      c++;
      if (start) start = 1'b0;
      if (sh_en) begin
        if (k < 7 && int'(sh_row) != er[k]) rows_ok = 0;
        k++;
        if (inject && !injected) begin
          start = 1'b1;
          grid_in = ~g;
          injected = 1;
        end
      end else if (sh_row != 3'd0) begin
        stray_row = 1;
      end
      if (done2) got_done2 = 1;
      if (done) got_done = 1;
    end
    start = 1'b0;
    chk({nm, " done_seen"}, 64'(got_done), 64'd1);
    chk({nm, " done_cycle"}, 64'(c), 64'(2 * en + 2));
    chk({nm, " clear_count"}, 64'(k), 64'(en));
    chk({nm, " sh_row_seq"}, 64'(rows_ok), 64'd1);
    chk({nm, " sh_row_idle_zero"}, 64'(stray_row), 64'd0);
    chk({nm, " grid_out"}, 64'(grid_out), 64'(eg));
    chk({nm, " lines_cleared"}, 64'(lines_cleared), 64'(en));
    chk({nm, " dut2_done"}, 64'(got_done2), 64'd1);
    chk({nm, " dut2_grid_out"}, 64'(grid_out2), 64'(eg));
    exp_score1 = sat(exp_score1 + pts(en, 1200));
    exp_score2 = sat(exp_score2 + pts(en, 65520));
    @(posedge clk);
    #1;
    chk({nm, " score"}, 64'(score), 64'(exp_score1));
    chk({nm, " score_sat"}, 64'(score2), 64'(exp_score2));
    chk({nm, " done_pulse"}, 64'(done), 64'd0);
    chk({nm, " busy_after"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    string       nm;
    logic [48:0] g;
    logic [48:0] eg;
    int          n;
    int          rows[7];
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{"empty",  49'h0,             49'h0,           0, '{0,0,0,0,0,0,0}};
    vt[1] = '{"row6",   49'h1FC0800000000, 49'h40000000000, 1, '{6,0,0,0,0,0,0}};
    vt[2] = '{"rows35", 49'h3F80FE00000,   49'h0,           2, '{5,4,0,0,0,0,0}};
    vt[3] = '{"all7",   49'h1FFFFFFFFFFFF, 49'h0,           7, '{6,6,6,6,6,6,6}};
    vt[4] = '{"rows03", 49'h0000FFFFFFF,   49'h0,           4, '{3,3,3,3,0,0,0}};

    #12;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset sh_en", 64'(sh_en), 64'd0);
    chk("reset grid_out", 64'(grid_out), 64'd0);
    chk("reset lines", 64'(lines_cleared), 64'd0);
    chk("reset score", 64'(score), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vt[i]) run_pass(vt[i].nm, vt[i].g, vt[i].eg, vt[i].n, vt[i].rows, 1'b0);

    // start pulsed during CLEAR must not disturb the pass
    run_pass("start_in_clear", vt[2].g, vt[2].eg, vt[2].n, vt[2].rows, 1'b1);

    // reset in the middle of a CLEAR
    begin
      int  w;
      bit  seen;
      @(negedge clk);
      grid_in = vt[3].g;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      w = 0; seen = 0;
      while (!seen && w < 10) begin
        @(negedge clk);
        w++;
        if (sh_en) seen = 1;
      end
      chk("midreset reached_clear", 64'(seen), 64'd1);
      reset = 1'b1;
      #1;
      chk("midreset busy", 64'(busy), 64'd0);
      chk("midreset sh_en", 64'(sh_en), 64'd0);
      chk("midreset sh_row", 64'(sh_row), 64'd0);
      chk("midreset grid_out", 64'(grid_out), 64'd0);
      chk("midreset lines", 64'(lines_cleared), 64'd0);
      chk("midreset score", 64'(score), 64'd0);
      chk("midreset score2", 64'(score2), 64'd0);
      exp_score1 = 0;
      exp_score2 = 0;
      @(negedge clk);
      reset = 1'b0;
    end

    // recovery after reset, then saturation on the high-SCORE_4 instance
    run_pass("after_reset", vt[4].g, vt[4].eg, vt[4].n, vt[4].rows, 1'b0);
    chk("sat first", 64'(score2), 64'hFFF0);
    run_pass("sat_second", vt[4].g, vt[4].eg, vt[4].n, vt[4].rows, 1'b0);
    chk("sat second", 64'(score2), 64'hFFFF);

    for (int t = 0; t < 30; t++) begin
      logic [48:0] g;
      g = '0;
      for (int r = 0; r < 7; r++) begin
        if ($urandom_range(0, 2) == 0) g[7*r +: 7] = 7'h7F;
        else g[7*r +: 7] = 7'($urandom_range(0, 126));
      end
      model(g);
      run_pass($sformatf("rand%0d", t), g, m_grid, m_n, m_rows, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
